// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sweep_checker
//  Description : Self-checking exerciser for a 2-input combinational gate.
//                Sweeps {A,B} through 00,01,10,11. Each vector is held for
//                SETTLE+1 cycles. The gate output is sampled on the last edge
//                of that window and compared against the selected truth table.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                start, gate_sel - sweep request and expected function
//                y_in            - output of the gate under test
//                a_out, b_out    - stimulus to the gate under test
//                busy, done      - sweep in progress / results valid
//                pass, err_count, fail_vec, cfg_err - sweep results
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [1:0] fail_vec,
   output logic       cfg_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] C_SETTLE = 4'(SETTLE);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [1:0] r_vec;
   logic [3:0] r_cnt;
   logic [2:0] r_sel;
   logic [2:0] r_err;
   logic [1:0] r_fail;
   logic       r_pass;
   logic       r_cfg;

   logic       w_start_ok;
   logic       w_sel_legal;
   logic       w_last_tick;
   logic       w_y_exp;
   logic       w_mismatch;
   logic [2:0] w_err_nxt;

   // start is only honoured outside a sweep
   assign w_start_ok  = start && (r_state != S_RUN);
   assign w_sel_legal = (gate_sel <= 3'd5);
   // final edge of the current vector's settle window
   assign w_last_tick = (r_state == S_RUN) && (r_cnt == C_SETTLE);

   always_comb begin
      w_y_exp = 1'b0;
      case (r_sel)
         3'd0:    w_y_exp =   r_vec[1] & r_vec[0];
         3'd1:    w_y_exp =   r_vec[1] | r_vec[0];
         3'd2:    w_y_exp =   r_vec[1] ^ r_vec[0];
         3'd3:    w_y_exp = ~(r_vec[1] & r_vec[0]);
         3'd4:    w_y_exp = ~(r_vec[1] | r_vec[0]);
         3'd5:    w_y_exp = ~(r_vec[1] ^ r_vec[0]);
         default: w_y_exp = 1'b0;
      endcase
   end

   assign w_mismatch = w_last_tick && (y_in != w_y_exp);
   // at most 4 mismatches exist, so the 3-bit count never wraps
   assign w_err_nxt  = r_err + {2'b00, w_mismatch};

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = w_sel_legal ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (w_last_tick && (r_vec == 2'd3)) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec  <= 2'd0;
         r_cnt  <= 4'd0;
         r_sel  <= 3'd0;
         r_err  <= 3'd0;
         r_fail <= 2'd0;
         r_pass <= 1'b0;
         r_cfg  <= 1'b0;
      end else if (w_start_ok) begin
         r_vec  <= 2'd0;
         r_cnt  <= 4'd0;
         r_err  <= 3'd0;
         r_fail <= 2'd0;
         r_pass <= 1'b0;
         if (w_sel_legal) begin
            r_sel <= gate_sel;
            r_cfg <= 1'b0;
         end else begin
            r_cfg <= 1'b1;
         end
      end else if (r_state == S_RUN) begin
         if (w_last_tick) begin
            r_cnt <= 4'd0;
            r_vec <= r_vec + 2'd1;
            r_err <= w_err_nxt;
            if (w_mismatch && (r_err == 3'd0)) begin
               r_fail <= r_vec;
            end
            if (r_vec == 2'd3) begin
               r_pass <= (w_err_nxt == 3'd0) && !r_cfg;
            end
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy      = (r_state == S_RUN);
      done      = (r_state == S_DONE);
      a_out     = (r_state == S_RUN) ? r_vec[1] : 1'b0;
      b_out     = (r_state == S_RUN) ? r_vec[0] : 1'b0;
      pass      = r_pass;
      err_count = r_err;
      fail_vec  = r_fail;
      cfg_err   = r_cfg;
   end

endmodule
`default_nettype wire
